// File: rtl/logic_op_pkg.sv
// Shared opcodes, FSM state encoding and default datapath width for the
// logic-unit command sequencer.
package logic_op_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOTA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

endpackage

// File: rtl/logic_op_sequencer.sv
// Registers commands onto the logic unit's A/B/S inputs, captures its result
// one cycle later and returns it over a valid/ready handshake.
module logic_op_sequencer
    import logic_op_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_acc,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    output logic [1:0]       lu_s,
    input  logic [WIDTH-1:0] lu_e,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic [7:0]       op_count
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] lu_a_q, lu_a_d;
    logic [WIDTH-1:0] lu_b_q, lu_b_d;
    logic [1:0]       lu_s_q, lu_s_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_zero_q, res_zero_d;
    logic [7:0]       op_count_q, op_count_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             res_valid_q, res_valid_d;

    // Next-state and datapath update; everything holds unless its state says otherwise.
    always_comb begin
        state_d    = state_q;
        lu_a_d     = lu_a_q;
        lu_b_d     = lu_b_q;
        lu_s_d     = lu_s_q;
        acc_d      = acc_q;
        res_data_d = res_data_q;
        res_zero_d = res_zero_q;
        op_count_d = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    lu_a_d  = cmd_acc ? acc_q : cmd_a;
                    lu_b_d  = cmd_b;
                    state_d = ST_EXEC;
                    case (cmd_op)
                        OP_AND:  lu_s_d = OP_AND;
                        OP_OR:   lu_s_d = OP_OR;
                        OP_XOR:  lu_s_d = OP_XOR;
                        default: lu_s_d = OP_NOTA;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // lu_e is only trusted here, a full cycle after the inputs settled.
                res_data_d = lu_e;
                acc_d      = lu_e;
                res_zero_d = (lu_e == {WIDTH{1'b0}});
                op_count_d = op_count_q + 8'd1;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags are registered from the next state to stay glitch-free.
        cmd_ready_d = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lu_a_q      <= {WIDTH{1'b0}};
            lu_b_q      <= {WIDTH{1'b0}};
            lu_s_q      <= 2'b00;
            acc_q       <= {WIDTH{1'b0}};
            res_data_q  <= {WIDTH{1'b0}};
            res_zero_q  <= 1'b0;
            op_count_q  <= 8'd0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lu_a_q      <= lu_a_d;
            lu_b_q      <= lu_b_d;
            lu_s_q      <= lu_s_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            op_count_q  <= op_count_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign res_valid = res_valid_q;
    assign lu_a      = lu_a_q;
    assign lu_b      = lu_b_q;
    assign lu_s      = lu_s_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed/randomised bench for logic_op_sequencer with a behavioural logic
// unit on lu_* and a scoreboard of expected results.
module tb_logic_op_sequencer;
    import logic_op_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_acc;
    logic [7:0] lu_a;
    logic [7:0] lu_b;
    logic [1:0] lu_s;
    logic [7:0] lu_e;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_zero;
    logic [7:0] op_count;

    typedef struct packed {
        logic [7:0] data;
        logic       zero;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_acc;
    logic [7:0] exp_count;

    always #5 clk = ~clk;

    logic_op_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
        .lu_a(lu_a), .lu_b(lu_b), .lu_s(lu_s), .lu_e(lu_e),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_zero(res_zero), .op_count(op_count)
    );

    // The logic unit itself: S=00 AND, 01 OR, 10 XOR, 11 NOT A.
    always_comb begin
        case (lu_s)
            2'b00:   lu_e = lu_a & lu_b;
            2'b01:   lu_e = lu_a | lu_b;
            2'b10:   lu_e = lu_a ^ lu_b;
            default: lu_e = ~lu_a;
        endcase
    end

    function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] r;
        if (op == OP_AND)      r = a & b;
        else if (op == OP_OR)  r = a | b;
        else if (op == OP_XOR) r = a ^ b;
        else                   r = ~a;
        return r;
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full command/result transaction; hold>0 keeps res_ready low that many cycles.
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic acc_sel, input logic [7:0] exp_data, input int hold);
        logic [7:0] exp_lu_a;
        exp_t       e;
        int         guard;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            step();
            guard++;
        end
        chk1("cmd_ready_wait", cmd_ready, 1'b1);
        exp_lu_a  = acc_sel ? exp_acc : a;
        res_ready = (hold == 0);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_acc   = acc_sel;
        exp_count = exp_count + 8'd1;
        sb.push_back('{data: exp_data, zero: (exp_data == 8'h00), cnt: exp_count});
        step();
        cmd_valid = 1'b0;
        chk8("lu_a", lu_a, exp_lu_a);
        chk8("lu_b", lu_b, b);
        chk8("lu_s", {6'd0, lu_s}, {6'd0, op});
        chk1("res_valid_exec", res_valid, 1'b0);
        chk1("cmd_ready_exec", cmd_ready, 1'b0);
        step();
        chk1("res_valid_done", res_valid, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk8("res_data", res_data, e.data);
            chk1("res_zero", res_zero, e.zero);
            chk8("op_count", op_count, e.cnt);
        end else begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = ~op;
            cmd_a     = ~a;
            cmd_b     = ~b;
            cmd_acc   = 1'b0;
            step();
            chk1("bp_res_valid", res_valid, 1'b1);
            chk8("bp_res_data", res_data, exp_data);
            chk1("bp_cmd_ready", cmd_ready, 1'b0);
            chk8("bp_lu_a", lu_a, exp_lu_a);
            chk8("bp_lu_b", lu_b, b);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        step();
        chk1("res_valid_clear", res_valid, 1'b0);
        chk1("cmd_ready_back", cmd_ready, 1'b1);
        exp_acc = exp_data;
    endtask

    task automatic check_reset_values(input string tag);
        chk1({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk1({tag, "_res_valid"}, res_valid, 1'b0);
        chk8({tag, "_res_data"}, res_data, 8'h00);
        chk1({tag, "_res_zero"}, res_zero, 1'b0);
        chk8({tag, "_lu_a"}, lu_a, 8'h00);
        chk8({tag, "_lu_b"}, lu_b, 8'h00);
        chk8({tag, "_lu_s"}, {6'd0, lu_s}, 8'h00);
        chk8({tag, "_op_count"}, op_count, 8'h00);
    endtask

    initial begin
        logic [1:0] r_op;
        logic [7:0] r_a, r_b;
        logic       r_acc;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        cmd_acc   = 1'b0;
        res_ready = 1'b1;
        exp_acc   = 8'h00;
        exp_count = 8'h00;
        step();
        step();
        rst_n = 1'b1;
        step();
        check_reset_values("reset");

        // Each opcode on F0/3C.
        run_op(OP_AND,  8'hF0, 8'h3C, 1'b0, 8'h30, 0);
        run_op(OP_OR,   8'hF0, 8'h3C, 1'b0, 8'hFC, 0);
        run_op(OP_XOR,  8'hF0, 8'h3C, 1'b0, 8'hCC, 0);
        run_op(OP_NOTA, 8'hF0, 8'h3C, 1'b0, 8'h0F, 0);

        // Accumulator chain: lu_a must see 30.
        run_op(OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 0);
        run_op(OP_XOR, 8'h00, 8'hFF, 1'b1, 8'hCF, 0);

        // Zero flag set then cleared.
        run_op(OP_XOR, 8'h55, 8'h55, 1'b0, 8'h00, 0);
        run_op(OP_OR,  8'h01, 8'h00, 1'b0, 8'h01, 0);

        // Backpressure for 5 cycles with competing commands.
        run_op(OP_OR, 8'hA0, 8'h05, 1'b0, 8'hA5, 5);

        // Reset while in EXEC discards the pending result.
        cmd_valid = 1'b1;
        cmd_op    = OP_OR;
        cmd_a     = 8'h5A;
        cmd_b     = 8'h81;
        cmd_acc   = 1'b0;
        step();
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
        check_reset_values("midop_reset");
        exp_acc   = 8'h00;
        exp_count = 8'h00;
        run_op(OP_OR, 8'h77, 8'h0A, 1'b1, 8'h0A, 0);

        // Drive the counter through 255 -> 0 -> 1.
        for (int k = 0; k < 254; k++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_a   = 8'($urandom);
            r_b   = 8'($urandom);
            r_acc = 1'($urandom_range(0, 1));
            run_op(r_op, r_a, r_b, r_acc, ref_op(r_op, r_acc ? exp_acc : r_a, r_b), 0);
        end
        chk8("count_255", op_count, 8'hFF);
        run_op(OP_XOR, 8'h12, 8'h34, 1'b0, 8'h26, 0);
        chk8("count_wrap", op_count, 8'h00);
        run_op(OP_NOTA, 8'h12, 8'h34, 1'b0, 8'hED, 0);
        chk8("count_after_wrap", op_count, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
